abs_pos_sequencer: RTL and testbench
====================================

ABS_POS_SEQUENCER -- requirements
Module: abs_pos_sequencer

Interface
REQ-001 Parameter NUM_AXES, default 4, number of axis channels (1..16).
REQ-002 Parameter POS_W, default 64, width of the calculated absolute position.
REQ-003 Parameter TIMEOUT_CYC, default 1023, maximum WAIT cycles per axis before abort.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level; request one sweep over enabled axes.
REQ-007 continuous  in  1  when high, a new sweep starts automatically after each sweep.
REQ-008 axis_en  in  NUM_AXES  per-axis enable mask.
REQ-009 axis_hw_counter, axis_set_pos_p1, axis_set_pos_p2, axis_counts_per_m  in  NUM_AXES*32 each  packed per-axis operands, axis i at bits [32i+31:32i].
REQ-010 calc_done  in  1  calculation core completion pulse.
REQ-011 calc_result  in  POS_W  core result, valid while calc_done high.
REQ-012 calc_start  out  1  one-cycle launch pulse to the core.
REQ-013 sel_hw_counter, sel_set_pos_p1, sel_set_pos_p2, sel_counts_per_m  out  32 each  operands of the selected axis.
REQ-014 sel_axis  out  $clog2(NUM_AXES) (min 1)  index of the selected axis.
REQ-015 abs_pos  out  NUM_AXES*POS_W  captured result per axis.
REQ-016 abs_pos_valid  out  NUM_AXES  sticky per-axis result-valid flags.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 sweep_done  out  1  one-cycle pulse at sweep completion.
REQ-019 timeout_err  out  NUM_AXES  sticky per-axis timeout flags.

Function
REQ-020 States: IDLE, SELECT, LAUNCH, WAIT, DONE; all outputs registered.
REQ-021 IDLE: start high at edge k -> SELECT at k; axis_en snapshotted into sweep mask at k, index pointer cleared to 0.
REQ-022 SELECT: pointer advances to lowest enabled axis at or above it; found -> sel_* and sel_axis loaded, LAUNCH next edge; none -> DONE.
REQ-023 LAUNCH: calc_start high exactly this one cycle; sel_* stable from LAUNCH until WAIT exits; -> WAIT.
REQ-024 WAIT: calc_done high -> abs_pos[sel_axis] <= calc_result, abs_pos_valid[sel_axis] <= 1, pointer+1, -> SELECT (or DONE if pointer was NUM_AXES-1).
REQ-025 Per-axis latency: calc_start to earliest capture 1 cycle; axis-to-axis overhead 2 cycles (SELECT, LAUNCH).
REQ-026 DONE: sweep_done high one cycle; continuous high -> SELECT with fresh axis_en snapshot, pointer 0; else -> IDLE.
REQ-027 start while busy is ignored; axis_en changes mid-sweep take effect next sweep only.
REQ-028 calc_done outside WAIT is ignored; calc_done in the LAUNCH cycle is ignored.
REQ-029 Empty mask: start -> SELECT -> DONE, sweep_done 2 cycles after start, no calc_start.
REQ-030 abs_pos of disabled or aborted axes keeps its previous value.

Reset
REQ-031 rst low: state IDLE, pointer 0, calc_start 0, sweep_done 0, busy 0, sel_* 0, sel_axis 0, abs_pos 0, abs_pos_valid 0, timeout_err 0, timeout counter 0.
REQ-032 Reset mid-sweep aborts immediately; a later calc_done is ignored (state IDLE).

Configuration
REQ-033 Macro ABS_POS_TIMEOUT_EN defined: counter runs in WAIT; at TIMEOUT_CYC cycles without calc_done, timeout_err[sel_axis] <= 1, no capture, proceed as REQ-024; calc_done on the expiry cycle wins (capture, no error).
REQ-034 Macro not defined: WAIT waits indefinitely, timeout_err tied 0, no counter logic.

Structure
REQ-035 Shared package abs_pos_pkg holds the state encoding and the 32-bit operand width constant.
REQ-036 Sub-module abs_pos_axis_pick: combinational lowest-set-bit-at-or-above-pointer search returning index and found flag.

Verification
REQ-037 NUM_AXES=4, axis_en=4'b1111, core returns done 5 cycles after calc_start with result 0x100+i -> four calc_start pulses, sel_axis 0..3, abs_pos[i]=0x100+i, valid=4'hF, one sweep_done.
REQ-038 axis_en=4'b1010 -> calc_start only for axes 1 and 3; abs_pos[0], abs_pos[2] stay 0, valid=4'b1010.
REQ-039 axis_en=0, start pulse -> sweep_done 2 cycles later, calc_start never asserted.
REQ-040 ABS_POS_TIMEOUT_EN, TIMEOUT_CYC=20, core silent for axis 2 -> timeout_err=4'b0100 after 20 WAIT cycles, axis 3 still computed.
REQ-041 continuous=1 for 3 sweeps, axis_en changed during sweep 2 -> new mask applied from sweep 3; start pulses while busy ignored.
REQ-042 rst low during WAIT of axis 1, then calc_done -> all outputs at reset values, no capture.

Source files
------------

// File: rtl/abs_pos_pkg.sv
// Shared definitions for the absolute-position sequencer: operand width,
// sweep state encoding and index-width helper.
package abs_pos_pkg;

    localparam int unsigned OPER_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/abs_pos_axis_pick.sv
// Combinational search for the lowest enabled axis at or above the pointer.
module abs_pos_axis_pick #(
    parameter int unsigned NUM_AXES = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [NUM_AXES-1:0] mask,
    input  logic [IDX_W-1:0]    ptr,
    output logic [IDX_W-1:0]    idx,
    output logic                found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            if (!found && mask[i] && (i >= 32'(ptr))) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/abs_pos_sequencer.sv
// Sweeps enabled axes through a shared position-calculation core and captures
// per-axis results. Define ABS_POS_TIMEOUT_EN to enable the per-axis WAIT timeout.
module abs_pos_sequencer
    import abs_pos_pkg::*;
#(
    parameter int unsigned NUM_AXES    = 4,
    parameter int unsigned POS_W       = 64,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [NUM_AXES-1:0]          axis_en,
    input  logic [NUM_AXES*OPER_W-1:0]   axis_hw_counter,
    input  logic [NUM_AXES*OPER_W-1:0]   axis_set_pos_p1,
    input  logic [NUM_AXES*OPER_W-1:0]   axis_set_pos_p2,
    input  logic [NUM_AXES*OPER_W-1:0]   axis_counts_per_m,
    input  logic                         calc_done,
    input  logic [POS_W-1:0]             calc_result,
    output logic                         calc_start,
    output logic [OPER_W-1:0]            sel_hw_counter,
    output logic [OPER_W-1:0]            sel_set_pos_p1,
    output logic [OPER_W-1:0]            sel_set_pos_p2,
    output logic [OPER_W-1:0]            sel_counts_per_m,
    output logic [idx_w(NUM_AXES)-1:0]   sel_axis,
    output logic [NUM_AXES*POS_W-1:0]    abs_pos,
    output logic [NUM_AXES-1:0]          abs_pos_valid,
    output logic                         busy,
    output logic                         sweep_done,
    output logic [NUM_AXES-1:0]          timeout_err
);

    localparam int unsigned IDX_W = idx_w(NUM_AXES);

    if (NUM_AXES < 1 || NUM_AXES > 16 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("abs_pos_sequencer: unsupported parameter set");
    end

    state_t               state, next_state;
    logic [NUM_AXES-1:0]  sweep_mask;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 ptr_last;
    logic                 expire;
    logic                 wait_exit;
    logic                 new_sweep;

    abs_pos_axis_pick #(
        .NUM_AXES (NUM_AXES),
        .IDX_W    (IDX_W)
    ) u_pick (
        .mask  (sweep_mask),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign ptr_last  = (ptr == IDX_W'(NUM_AXES - 1));
    assign wait_exit = (state == ST_WAIT) && (calc_done || expire);
    assign new_sweep = ((state == ST_IDLE) && start) || ((state == ST_DONE) && continuous);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (start) next_state = ST_SELECT;
            ST_SELECT: next_state = pick_found ? ST_LAUNCH : ST_DONE;
            ST_LAUNCH: next_state = ST_WAIT;
            ST_WAIT:   if (wait_exit) next_state = ptr_last ? ST_DONE : ST_SELECT;
            ST_DONE:   next_state = continuous ? ST_SELECT : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Status pulses are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            calc_start       <= 1'b0;
            sweep_done       <= 1'b0;
            busy             <= 1'b0;
            sweep_mask       <= '0;
            ptr              <= '0;
            sel_axis         <= '0;
            sel_hw_counter   <= '0;
            sel_set_pos_p1   <= '0;
            sel_set_pos_p2   <= '0;
            sel_counts_per_m <= '0;
            abs_pos          <= '0;
            abs_pos_valid    <= '0;
        end else begin
            calc_start <= (next_state == ST_LAUNCH);
            sweep_done <= (next_state == ST_DONE);
            busy       <= (next_state != ST_IDLE);
            if (new_sweep) begin
                sweep_mask <= axis_en;
                ptr        <= '0;
            end
            if ((state == ST_SELECT) && pick_found) begin
                ptr              <= pick_idx;
                sel_axis         <= pick_idx;
                sel_hw_counter   <= axis_hw_counter[32'(pick_idx)*OPER_W +: OPER_W];
                sel_set_pos_p1   <= axis_set_pos_p1[32'(pick_idx)*OPER_W +: OPER_W];
                sel_set_pos_p2   <= axis_set_pos_p2[32'(pick_idx)*OPER_W +: OPER_W];
                sel_counts_per_m <= axis_counts_per_m[32'(pick_idx)*OPER_W +: OPER_W];
            end
            if (wait_exit) begin
                if (calc_done) begin
                    abs_pos[32'(sel_axis)*POS_W +: POS_W] <= calc_result;
                    abs_pos_valid[sel_axis]               <= 1'b1;
                end
                if (!ptr_last) ptr <= ptr + IDX_W'(1);
            end
        end
    end

`ifdef ABS_POS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tcnt;

    // Expiry on the TIMEOUT_CYC-th WAIT cycle; a coincident calc_done takes priority.
    assign expire = (state == ST_WAIT) && !calc_done && (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt        <= '0;
            timeout_err <= '0;
        end else begin
            if ((state == ST_WAIT) && !calc_done && !expire) tcnt <= tcnt + TW'(1);
            else                                             tcnt <= '0;
            if (expire) timeout_err[sel_axis] <= 1'b1;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_abs_pos_sequencer.sv
// Scoreboard bench for abs_pos_sequencer: expected launch order queued per sweep,
// a behavioural core answers calc_start, captured positions checked against a model.
module tb_abs_pos_sequencer;

    localparam int unsigned NA = 4;
    localparam int unsigned PW = 64;
`ifdef ABS_POS_TIMEOUT_EN
    localparam int unsigned TO_CYC = 20;
`else
    localparam int unsigned TO_CYC = 1023;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              continuous;
    logic [NA-1:0]     axis_en;
    logic [NA*32-1:0]  axis_hw_counter;
    logic [NA*32-1:0]  axis_set_pos_p1;
    logic [NA*32-1:0]  axis_set_pos_p2;
    logic [NA*32-1:0]  axis_counts_per_m;
    logic              calc_done;
    logic [PW-1:0]     calc_result;
    logic              calc_start;
    logic [31:0]       sel_hw_counter;
    logic [31:0]       sel_set_pos_p1;
    logic [31:0]       sel_set_pos_p2;
    logic [31:0]       sel_counts_per_m;
    logic [1:0]        sel_axis;
    logic [NA*PW-1:0]  abs_pos;
    logic [NA-1:0]     abs_pos_valid;
    logic              busy;
    logic              sweep_done;
    logic [NA-1:0]     timeout_err;

    abs_pos_sequencer #(
        .NUM_AXES    (NA),
        .POS_W       (PW),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .continuous        (continuous),
        .axis_en           (axis_en),
        .axis_hw_counter   (axis_hw_counter),
        .axis_set_pos_p1   (axis_set_pos_p1),
        .axis_set_pos_p2   (axis_set_pos_p2),
        .axis_counts_per_m (axis_counts_per_m),
        .calc_done         (calc_done),
        .calc_result       (calc_result),
        .calc_start        (calc_start),
        .sel_hw_counter    (sel_hw_counter),
        .sel_set_pos_p1    (sel_set_pos_p1),
        .sel_set_pos_p2    (sel_set_pos_p2),
        .sel_counts_per_m  (sel_counts_per_m),
        .sel_axis          (sel_axis),
        .abs_pos           (abs_pos),
        .abs_pos_valid     (abs_pos_valid),
        .busy              (busy),
        .sweep_done        (sweep_done),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   exp_axis_q[$];
    logic [PW-1:0] exp_pos [NA];
    logic [NA-1:0] exp_valid;
    logic [NA-1:0] exp_terr;
    int unsigned   core_delay  = 5;
    int unsigned   silent_axis = 99;
    int unsigned   tag         = 0;
    bit            spurious    = 1'b0;
    bit            inject      = 1'b0;
    int unsigned   n_sweep     = 0;
    int unsigned   exp_sweeps  = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] result_of(input int unsigned t, input int unsigned ax);
        return PW'(t * 65536 + 256 + ax);
    endfunction

    // Behavioural calculation core: answers each launch core_delay cycles later.
    initial begin : core
        int unsigned pend;
        int unsigned pend_ax;
        pend = 0;
        pend_ax = 0;
        calc_done = 1'b0;
        calc_result = '0;
        forever begin
            @(negedge clk);
            calc_done = 1'b0;
            if (inject) begin
                calc_done = 1'b1;
                calc_result = 64'hBAD;
            end
            if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    calc_done = 1'b1;
                    calc_result = result_of(tag, pend_ax);
                end
            end
            if (calc_start) begin
                pend_ax = 32'(sel_axis);
                pend = (pend_ax == silent_axis) ? 0 : core_delay;
                if (spurious) begin
                    calc_done = 1'b1;
                    calc_result = 64'hDEAD;
                end
            end
        end
    end

    initial begin : mon
        int unsigned ax;
        forever begin
            @(negedge clk);
            if (sweep_done) n_sweep++;
            if (calc_start) begin
                if (exp_axis_q.size() == 0) begin
                    check_eq("calc_start_unexpected", calc_start, 0);
                end else begin
                    ax = exp_axis_q.pop_front();
                    check_eq("sel_axis", sel_axis, ax);
                    check_eq("sel_hw_counter", sel_hw_counter, 32'hA000_0000 + ax);
                    check_eq("sel_set_pos_p1", sel_set_pos_p1, 32'hB100_0000 + ax);
                    check_eq("sel_set_pos_p2", sel_set_pos_p2, 32'hC200_0000 + ax);
                    check_eq("sel_counts_per_m", sel_counts_per_m, 32'hD300_0000 + ax);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, summary incomplete (%0d errors so far)", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check_state();
        for (int unsigned i = 0; i < NA; i++)
            check_eq($sformatf("abs_pos%0d", i), abs_pos[i*PW +: PW], exp_pos[i]);
        check_eq("abs_pos_valid", abs_pos_valid, exp_valid);
        check_eq("timeout_err", timeout_err, exp_terr);
    endtask

    task automatic reset_checks();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_calc_start", calc_start, 0);
        check_eq("rst_sweep_done", sweep_done, 0);
        check_eq("rst_sel_axis", sel_axis, 0);
        check_eq("rst_sel_hw", sel_hw_counter, 0);
        check_eq("rst_sel_p1", sel_set_pos_p1, 0);
        check_eq("rst_sel_p2", sel_set_pos_p2, 0);
        check_eq("rst_sel_cpm", sel_counts_per_m, 0);
        check_state();
    endtask

    task automatic apply_model(input logic [NA-1:0] mask, input logic [NA-1:0] to_mask);
        for (int unsigned i = 0; i < NA; i++) begin
            if (mask[i] && to_mask[i]) begin
                exp_terr[i] = 1'b1;
            end else if (mask[i]) begin
                exp_pos[i] = result_of(tag, i);
                exp_valid[i] = 1'b1;
            end
        end
        exp_sweeps++;
    endtask

    task automatic push_mask(input logic [NA-1:0] mask);
        for (int unsigned i = 0; i < NA; i++)
            if (mask[i]) exp_axis_q.push_back(i);
    endtask

    task automatic wait_sweep(input int unsigned budget, output int unsigned cyc);
        cyc = 0;
        while (!sweep_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("sweep_done_seen", sweep_done, 1);
    endtask

    task automatic wait_launch(input int unsigned ax, input int unsigned budget);
        int unsigned cyc;
        cyc = 0;
        while (!(calc_start && 32'(sel_axis) == ax) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("launch_seen", calc_start, 1);
    endtask

    task automatic finish_sweep();
        @(negedge clk);
        check_eq("sweep_done_pulse", sweep_done, 0);
        @(negedge clk);
        check_eq("busy_after_sweep", busy, 0);
        check_state();
    endtask

    // Single sweep; axis_en is scrambled right after start to prove the snapshot.
    task automatic run_sweep(input logic [NA-1:0] mask, input int unsigned exp_cyc,
                             input logic [NA-1:0] to_mask);
        int unsigned cyc;
        push_mask(mask);
        @(negedge clk);
        axis_en = mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        axis_en = ~mask;
        check_eq("busy_in_sweep", busy, 1);
        wait_sweep(200, cyc);
        check_eq("sweep_cycles", cyc, exp_cyc);
        apply_model(mask, to_mask);
        finish_sweep();
    endtask

    initial begin : main
        int unsigned cyc;
        int unsigned launches_before;
        rst = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        axis_en = '0;
        for (int unsigned i = 0; i < NA; i++) begin
            axis_hw_counter[i*32 +: 32]   = 32'hA000_0000 + i;
            axis_set_pos_p1[i*32 +: 32]   = 32'hB100_0000 + i;
            axis_set_pos_p2[i*32 +: 32]   = 32'hC200_0000 + i;
            axis_counts_per_m[i*32 +: 32] = 32'hD300_0000 + i;
            exp_pos[i] = '0;
        end
        exp_valid = '0;
        exp_terr = '0;

        repeat (3) @(negedge clk);
        reset_checks();
        rst = 1'b1;
        @(negedge clk);

        tag = 0;
        run_sweep(4'b1111, 28, 4'b0000);
        tag = 1;
        run_sweep(4'b1010, 14, 4'b0000);

        // calc_done while idle must not capture
        @(posedge clk);
        #1 inject = 1'b1;
        @(posedge clk);
        #1 inject = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_state();

        // empty mask: sweep_done two cycles after start, no launch
        launches_before = exp_axis_q.size();
        @(negedge clk);
        axis_en = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("empty_sd_early", sweep_done, 0);
        @(negedge clk);
        check_eq("empty_sd_at_2", sweep_done, 1);
        check_eq("empty_no_launch", calc_start, 0);
        apply_model('0, '0);
        finish_sweep();
        check_eq("empty_queue", exp_axis_q.size(), launches_before);

        // continuous: three sweeps, mask change in sweep 2 applies to sweep 3
        tag = 3;
        continuous = 1'b1;
        push_mask(4'b0011);
        push_mask(4'b0011);
        push_mask(4'b1100);
        @(negedge clk);
        axis_en = 4'b0011;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sweep(100, cyc);
        apply_model(4'b0011, '0);
        @(negedge clk);
        check_eq("cont_busy2", busy, 1);
        axis_en = 4'b1100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sweep(100, cyc);
        apply_model(4'b0011, '0);
        @(negedge clk);
        continuous = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sweep(100, cyc);
        apply_model(4'b1100, '0);
        finish_sweep();
        check_eq("cont_queue_drained", exp_axis_q.size(), 0);

        // calc_done during LAUNCH is ignored
        tag = 4;
        spurious = 1'b1;
        push_mask(4'b0100);
        @(negedge clk);
        axis_en = 4'b0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_launch(2, 20);
        @(negedge clk);
        spurious = 1'b0;
        check_eq("launch_done_ignored", abs_pos[2*PW +: PW], exp_pos[2]);
        wait_sweep(100, cyc);
        apply_model(4'b0100, '0);
        finish_sweep();

        // reset in WAIT of axis 1; the late calc_done must be ignored
        tag = 5;
        push_mask(4'b0011);
        @(negedge clk);
        axis_en = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_launch(1, 40);
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned i = 0; i < NA; i++) exp_pos[i] = '0;
        exp_valid = '0;
        exp_terr = '0;
        @(negedge clk);
        reset_checks();
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        reset_checks();
        check_eq("rst_queue_drained", exp_axis_q.size(), 0);

`ifdef ABS_POS_TIMEOUT_EN
        tag = 6;
        silent_axis = 2;
        run_sweep(4'b1111, 43, 4'b0100);
        silent_axis = 99;
        tag = 7;
        core_delay = 20;
        run_sweep(4'b0001, 23, 4'b0000);
        tag = 8;
        core_delay = 21;
        run_sweep(4'b0010, 23, 4'b0010);
        core_delay = 5;
        repeat (4) @(negedge clk);
        check_state();
`endif

        @(negedge clk);
        check_eq("sweep_count", n_sweep, exp_sweeps);
        check_eq("final_queue", exp_axis_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
